// File: rtl/viterbi_acs_r2.sv
// Radix-2 add-compare-select unit for a rate-1/2 Viterbi decoder.
// It updates 2^(K-1) path metrics per step and emits survivor decisions plus the best state.
module viterbi_acs_r2 #(
    parameter int             K       = 3,
    parameter logic [K-1:0]   G0      = 3'b111,
    parameter logic [K-1:0]   G1      = 3'b101,
    parameter int             BM_W    = 2,
    parameter int             PM_W    = 8,
    parameter int             INIT_PM = 64,
    localparam int            NS      = 1 << (K - 1),
    localparam int            SW      = K - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              en_a,
    input  logic [4*BM_W-1:0] i_bm,
    output logic              o_valid,
    output logic [NS-1:0]     o_dec,
    output logic [SW-1:0]     o_best_state,
    output logic [PM_W-1:0]   o_best_pm,
    output logic              o_norm,
    output logic [15:0]       o_step_cnt
);

    localparam logic [PM_W:0] HALF = (PM_W + 1)'(1) << (PM_W - 1);

    logic [PM_W-1:0] pm_q [NS];
    logic [PM_W-1:0] pm_d [NS];
    logic [PM_W:0]   cand0 [NS];
    logic [PM_W:0]   cand1 [NS];
    logic [PM_W:0]   new_pm [NS];
    logic [NS-1:0]   dec;
    logic            all_high;
    logic [SW-1:0]   best_state;
    logic [PM_W-1:0] best_pm;

    // The encoder register for a transition into ns from predecessor {ns[SW-2:0], b} is {ns, b}.
    function automatic logic [1:0] codeword(input logic [SW-1:0] ns, input logic b);
        logic [K-1:0] r;
        r = {ns, b};
        return {^(r & G0), ^(r & G1)};
    endfunction

    function automatic logic [PM_W:0] branch(input logic [4*BM_W-1:0] bm, input logic [1:0] n);
        return (PM_W + 1)'(bm[int'(n)*BM_W +: BM_W]);
    endfunction

    function automatic logic [SW-1:0] pred(input logic [SW-1:0] ns, input logic b);
        logic [K-1:0] r;
        r = {ns, b};
        return r[SW-1:0];
    endfunction

    // NOTE: every variable in always_comb gets a value on every path, so no latches are inferred.
    always_comb begin
        all_high = 1'b1;
        for (int s = 0; s < NS; s++) begin
            cand0[s]  = {1'b0, pm_q[pred(SW'(s), 1'b0)]} + branch(i_bm, codeword(SW'(s), 1'b0));
            cand1[s]  = {1'b0, pm_q[pred(SW'(s), 1'b1)]} + branch(i_bm, codeword(SW'(s), 1'b1));
            dec[s]    = cand1[s] < cand0[s];
            new_pm[s] = dec[s] ? cand1[s] : cand0[s];
            if (new_pm[s] < HALF) all_high = 1'b0;
        end
        for (int s = 0; s < NS; s++) begin
            pm_d[s] = PM_W'(all_high ? new_pm[s] - HALF : new_pm[s]);
        end
        best_state = '0;
        best_pm    = pm_d[0];
        for (int s = 1; s < NS; s++) begin
            if (pm_d[s] < best_pm) begin
                best_pm    = pm_d[s];
                best_state = SW'(s);
            end
        end
    end

    // NOTE: the metric array is reset on purpose; its start values define the trellis origin state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < NS; s++) pm_q[s] <= (s == 0) ? '0 : PM_W'(INIT_PM);
            o_valid      <= 1'b0;
            o_dec        <= '0;
            o_best_state <= '0;
            o_best_pm    <= '0;
            o_norm       <= 1'b0;
            o_step_cnt   <= '0;
        end else if (i_start) begin
            for (int s = 0; s < NS; s++) pm_q[s] <= (s == 0) ? '0 : PM_W'(INIT_PM);
            o_valid    <= 1'b0;
            o_norm     <= 1'b0;
            o_step_cnt <= '0;
        end else if (en_a) begin
            for (int s = 0; s < NS; s++) pm_q[s] <= pm_d[s];
            o_valid      <= 1'b1;
            o_dec        <= dec;
            o_best_state <= best_state;
            o_best_pm    <= best_pm;
            o_norm       <= all_high;
            if (o_step_cnt != 16'hFFFF) o_step_cnt <= o_step_cnt + 16'd1;
        end else begin
            o_valid <= 1'b0;
            o_norm  <= 1'b0;
        end
    end

endmodule
